// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1; 8E1 when UART_RX_PARITY_EN is defined) feeding a
// 2^DEPTH_LOG2-entry byte FIFO with sticky framing/overflow error flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overflow,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    input  logic       err_clr
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0]         HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]         FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    // ---------------- input synchronizer ----------------
    logic sync1_q, sync2_q;
    logic rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // ---------------- receiver FSM ----------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_req;
    logic            frame_set;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_set;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d   = S_START;
                    bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                // Mid-start re-check: a line that is high again was a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    par_bad_d  = ^{shift_q, rx_s};
                    parity_set = ^{shift_q, rx_s};
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        push_req = ~par_bad_q;
`else
                        push_req = 1'b1;
`endif
                        state_d  = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A held break raises exactly one framing error.
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;
    logic                  do_pop, do_push, ovf_set;
`ifdef UART_RX_PARITY_EN
    logic                  parity_err_q, parity_err_d;
`endif

    always_comb begin
        do_pop  = rd_en & ~empty_q;
        // A pop in the same cycle frees the slot, so a push at full is legal then.
        do_push = push_req & (~full_q | do_pop);
        ovf_set = push_req & full_q & ~do_pop;

        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_push);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);

        rd_data_d  = do_pop ? mem_q[rd_ptr_q] : rd_data_q;
        rd_valid_d = do_pop;

        // Clear wins over a same-cycle set.
        frame_err_d = ~err_clr & (frame_err_q | frame_set);
        overflow_d  = ~err_clr & (overflow_q | ovf_set);
`ifdef UART_RX_PARITY_EN
        parity_err_d = ~err_clr & (parity_err_q | parity_set);
`endif
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            rd_data_q   <= 8'd0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed table, multi-cycle corner sequences and
// randomized traffic checked against a queue-based model of the FIFO.
module tb_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int DLOG  = 5;
    localparam int DEPTH = 32;

    localparam int OP_SEND = 0;
    localparam int OP_BAD  = 1;
    localparam int OP_READ = 2;
    localparam int OP_CLR  = 3;

    typedef struct {
        int         op;
        logic [7:0] data;
        logic       exp_empty;
        logic       exp_fe;
        logic       exp_ov;
        logic       exp_vld;
        logic [7:0] exp_dat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, rx, rd_en, err_clr;
    logic [7:0] rd_data;
    logic       rd_valid, empty, full, frame_err, overflow;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DLOG)) dut (
        .clk       (clk),
        .reset     (rst),
        .rx_serial (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .frame_err (frame_err),
        .overflow  (overflow),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .err_clr   (err_clr)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int cycles);
        rx = v;
        tick(cycles);
    endtask

    // Full frame; stop_low_bits > 0 holds the stop bit low that many bit times.
    task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b, CPB);
`endif
        if (stop_low_bits > 0) drive_bit(1'b0, CPB * stop_low_bits);
        drive_bit(1'b1, CPB);
        tick(8);
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic read_chk(input string nm, input logic exp_v, input logic [7:0] exp_d);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk({nm, "_valid"}, rd_valid, exp_v);
        if (exp_v) chk({nm, "_data"}, rd_data, exp_d);
        tick(1);
        chk({nm, "_pulse_end"}, rd_valid, 1'b0);
    endtask

    task automatic chk_flags(input string nm, input logic e, input logic f,
                             input logic fe, input logic ov);
        chk({nm, "_empty"}, empty, e);
        chk({nm, "_full"}, full, f);
        chk({nm, "_frame_err"}, frame_err, fe);
        chk({nm, "_overflow"}, overflow, ov);
    endtask

    vec_t       tbl [13];
    logic [7:0] mq [$];
    logic       m_fe, m_ov;
    int         lat;
    logic       got_v;
    logic [7:0] got_d;

    initial begin
        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        tbl[0]  = '{OP_SEND, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{OP_READ, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
        tbl[2]  = '{OP_READ, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{OP_BAD,  8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{OP_SEND, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{OP_READ, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
        tbl[6]  = '{OP_CLR,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{OP_SEND, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{OP_SEND, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{OP_READ, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[10] = '{OP_READ, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[11] = '{OP_SEND, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[12] = '{OP_READ, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81};

        // Reset state
        @(negedge clk);
        tick(3);
        chk_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        tick(4);

        // 0xA5: empty should fall close to 10 bit times after the start edge
        lat = -1;
        fork
            send_frame(8'hA5, 0);
            begin
                for (int i = 1; i <= 200; i++) begin
                    tick(1);
                    if (!empty && lat < 0) lat = i;
                end
            end
        join
        chk("a5_empty_fall_latency_in_window", (lat >= 150 && lat <= 160), 1'b1);
        read_chk("a5_read", 1'b1, 8'hA5);
        chk("a5_empty_after", empty, 1'b1);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            string nm;
            nm = $sformatf("tbl%0d", i);
            case (tbl[i].op)
                OP_SEND: send_frame(tbl[i].data, 0);
                OP_BAD:  send_frame(tbl[i].data, 3);
                OP_CLR:  clr_pulse();
                default: begin
                    rd_en = 1'b1;
                    tick(1);
                    rd_en = 1'b0;
                end
            endcase
            chk({nm, "_rd_valid"}, rd_valid, tbl[i].exp_vld);
            if (tbl[i].exp_vld) chk({nm, "_rd_data"}, rd_data, tbl[i].exp_dat);
            chk({nm, "_empty"}, empty, tbl[i].exp_empty);
            chk({nm, "_frame_err"}, frame_err, tbl[i].exp_fe);
            chk({nm, "_overflow"}, overflow, tbl[i].exp_ov);
            tick(1);
        end

        // Short low glitch on the idle line is ignored
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        chk_flags("glitch", 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h42, 0);
        read_chk("after_glitch", 1'b1, 8'h42);

        // err_clr held across a framing error: clear wins, event lost
        err_clr = 1'b1;
        send_frame(8'h77, 1);
        err_clr = 1'b0;
        tick(1);
        chk_flags("clr_priority", 1'b1, 1'b0, 1'b0, 1'b0);

        // 33 bytes without reading: 32 stored, the last dropped with overflow
        for (int b = 0; b < 33; b++) begin
            send_frame(8'(b), 0);
            if (b == 31) chk_flags("fill32", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk_flags("fill33", 1'b0, 1'b1, 1'b0, 1'b1);
        for (int b = 0; b < 32; b++) read_chk($sformatf("drain%0d", b), 1'b1, 8'(b));
        chk_flags("drained", 1'b1, 1'b0, 1'b0, 1'b1);
        clr_pulse();
        chk("ovf_cleared", overflow, 1'b0);

        // Full FIFO, pop on the exact push cycle of a new byte
        for (int b = 0; b < 32; b++) send_frame(8'(8'h80 + b), 0);
        chk("refill_full", full, 1'b1);
        got_v = 1'b0;
        got_d = 8'h00;
        fork
            send_frame(8'hEE, 0);
            begin
                tick(154);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
                got_v = rd_valid;
                got_d = rd_data;
            end
        join
        chk("pushpop_valid", got_v, 1'b1);
        chk("pushpop_data", got_d, 8'h80);
        chk_flags("pushpop", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int b = 1; b < 32; b++) read_chk($sformatf("pp_drain%0d", b), 1'b1, 8'(8'h80 + b));
        read_chk("pp_last_new", 1'b1, 8'hEE);
        chk("pp_empty", empty, 1'b1);

        // Reset mid-DATA with 3 bytes queued and flags raised
        send_frame(8'h01, 0);
        send_frame(8'h02, 0);
        send_frame(8'h03, 0);
        send_frame(8'h99, 2);
        chk("pre_reset_frame_err", frame_err, 1'b1);
        rx = 1'b0;
        tick(60);
        rst = 1'b1;
        rx = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk_flags("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_reset_rd_valid", rd_valid, 1'b0);
        tick(4);
        send_frame(8'h5A, 0);
        read_chk("post_reset", 1'b1, 8'h5A);
        read_chk("post_reset_empty_read", 1'b0, 8'h00);

        // Randomized traffic vs queue model
        mq.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        for (int it = 0; it < 70; it++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            b = 8'($urandom);
            if (r < 55) begin
                send_frame(b, 0);
                if (mq.size() < DEPTH) mq.push_back(b);
                else m_ov = 1'b1;
            end else if (r < 65) begin
                send_frame(b, $urandom_range(1, 3));
                m_fe = 1'b1;
            end else if (r < 92) begin
                if (mq.size() > 0) read_chk($sformatf("rnd%0d_pop", it), 1'b1, mq.pop_front());
                else read_chk($sformatf("rnd%0d_pop_empty", it), 1'b0, 8'h00);
            end else begin
                clr_pulse();
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            chk_flags($sformatf("rnd%0d", it), mq.size() == 0, mq.size() == DEPTH, m_fe, m_ov);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
